fpa_seq: RTL and testbench
==========================

# fpa_seq

Parametrised, multi-cycle floating-point adder/subtractor that succeeds the combinational half-precision `fpa`. It accepts one operand pair per transaction over a valid/ready handshake, adds or subtracts them, and returns a normalised, rounded result with status flags. The datapath is iterative: alignment and normalisation each shift one bit per cycle, so latency depends on the operands. It sits between operand-issue logic and result consumers in the FP datapath.

## Interface
- `EXP_W`, 5: exponent field width; must be ≥3.
- `MAN_W`, 10: stored mantissa width without the hidden bit; must be ≥2.
- `W` (local): 1+EXP_W+MAN_W. Bias is 2^(EXP_W-1)-1.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  W  operand A in IEEE-style format.
- `b`  in  W  operand B.
- `sub`  in  1  1: compute a−b; 0: compute a+b.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  W  sum or difference.
- `flags`  out  4  {invalid, overflow, zero, inexact}.

## Operation
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0.
- Encoding: an exponent field of 0 means zero. Subnormal inputs are flushed to ±0. An all-ones exponent with mantissa 0 is ±Inf; with a nonzero mantissa it is NaN.
- IDLE: when `in_valid`&&`in_ready`, capture a and b. Capture b with its sign XOR `sub`. Go to CHECK.
- CHECK handles special cases and goes straight to DONE:
  - Any NaN, or Inf−Inf: canonical NaN (sign 0, exponent all ones, mantissa MSB 1); invalid=1.
  - Otherwise, either operand Inf: that Inf.
  - One operand zero: the other operand, unchanged.
  - Both zero: +0, zero=1.
  - Otherwise: order the operands so A has the larger magnitude (compare exponent, then mantissa). Set d=eA−eB and the effective operation. Go to ALIGN if d>0, else ADD.
- Mantissa working register: MAN_W+5 bits, holding carry, hidden bit, mantissa, guard, round and sticky.
- ALIGN: each cycle, shift B right by 1 with the sticky bit OR-accumulated, and decrement d. The number of ALIGN cycles is min(d, MAN_W+3). If d exceeds MAN_W+3, B collapses to sticky-only on the final cycle. Then go to ADD.
- ADD: one cycle. Effective add is A+B; effective subtract is A−B, which is never negative. Sign is A's sign. Then go to NORM.
- NORM: takes n cycles, with n ≥ 1:
  - Zero sum: result +0, zero=1, one cycle.
  - Carry set: shift right 1 (sticky kept) and increment the exponent, one cycle.
  - Otherwise, one cycle per left shift until the hidden bit is 1, decrementing the exponent each time. An already-normalised sum takes one cycle.
  - If the exponent reaches 0: flush to signed zero with zero=1 and inexact=1.
- ROUND: one cycle. Apply the rounding mode (see Configuration). A mantissa carry-out increments the exponent. An exponent reaching all-ones gives ±Inf with overflow=1 and inexact=1. inexact=1 whenever any of G/R/S is nonzero.
- DONE: `out_valid`=1. `result` and `flags` stay stable until `out_ready`, then go to IDLE.
- `in_ready` is low in every state except IDLE; there is no overlap between transactions.

## Timing
- Count edges after the accepting edge until `out_valid` rises:
  - Special case: 1.
  - Normal path: 3 + min(d, MAN_W+3) + n.
- In DONE with `out_ready`=1: the accept edge clears `out_valid` and raises `in_ready`. The next operand pair is accepted no earlier than the following edge.
- `in_valid` is ignored outside IDLE. Operands need not be held after the accept edge.
- `rst` in any state returns to the reset values on that edge. Any in-flight result is discarded.

## Configuration
- `FPA_RNE_EN` defined: round-to-nearest, ties-to-even, using G/R/S.
- `FPA_RNE_EN` undefined: truncate toward zero, with no ROUND increment. The ROUND state is still present, so latency is unchanged. inexact is still reported.

## Test plan
- 1.0+1.0: 0x3C00+0x3C00, sub=0 → 0x4000, flags=0, `out_valid` 4 edges after accept.
- 1.5+0.25: 0x3E00+0x3400 → 0x3F00, flags=0, latency 6 (d=2).
- 1.0−1.0: sub=1 → 0x0000, zero=1, latency 4. Separately, 0x7BFF+0x7BFF → 0x7C00, overflow=1, inexact=1.
- Inf−Inf: 0x7C00+0xFC00 → 0x7E00, invalid=1, latency 1. Separately, 0x0000+0x3C00 → 0x3C00.
- Rounding: 0x3C00+0x1200 (1+1.5 ulp/2), latency 15. With `FPA_RNE_EN` → 0x3C01, inexact=1. Without → 0x3C00, inexact=1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 3 cycles in DONE → `result` stable, `in_ready`=0.
  - Assert `rst` during ALIGN → next edge shows IDLE, `out_valid`=0, `in_ready`=1; a fresh 1.0+1.0 then completes normally.

Source files
------------

// File: rtl/fpa_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpa_seq_if
//  Description : Operand/result handshake bundle for the iterative FP adder.
//                The master side issues operand pairs and accepts results.
//                The slave side is the adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface fpa_seq_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fpa_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpa_seq
//  Description : Iterative floating-point adder/subtractor. Alignment and
//                normalisation shift one bit per cycle. flags are
//                {invalid, overflow, zero, inexact}.
//                Macro FPA_RNE_EN selects round-to-nearest-even; without it
//                the result is truncated toward zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fpa_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  wire        clk,
    input  wire        rst,
    fpa_seq_if.slave   bus
);
    localparam int W         = 1 + EXP_W + MAN_W;
    localparam int MW        = MAN_W + 5;           // carry,hidden,man,G,R,S
    localparam int ALIGN_MAX = MAN_W + 3;
    localparam int CLG       = $clog2(MAN_W + 4);
    localparam int CW        = (EXP_W > CLG) ? EXP_W : CLG;

    localparam logic [EXP_W-1:0] C_EXP_ONES  = '1;
    localparam logic [CW-1:0]    C_ALIGN_MAX = CW'(ALIGN_MAX);
    localparam logic [CW-1:0]    C_ONE       = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_ROUND = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state_q;
    logic            in_ready_q, out_valid_q;
    logic [W-1:0]    result_q, a_q, b_q;
    logic [3:0]      flags_q;
    logic            sa_q, eff_sub_q, big_q;
    logic [EXP_W:0]  ea_q;              // one spare bit catches exponent overflow
    logic [MW-1:0]   ma_q, mb_q;
    logic [CW-1:0]   cnt_q;
    logic            z_q, zsign_q, zinex_q;

    // Operand decode, magnitude ordering and alignment count
    logic [EXP_W-1:0] ea_raw, eb_raw, ex_d, ey_d, d_d;
    logic [MAN_W-1:0] fa_raw, fb_raw, fx_d, fy_d;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap_d;
    logic [CW-1:0]    d_ext, cnt_init_d;

    always_comb begin
        ea_raw = a_q[W-2:MAN_W];
        eb_raw = b_q[W-2:MAN_W];
        fa_raw = a_q[MAN_W-1:0];
        fb_raw = b_q[MAN_W-1:0];
        a_zero = (ea_raw == '0);
        b_zero = (eb_raw == '0);
        a_inf  = (ea_raw == C_EXP_ONES) && (fa_raw == '0);
        b_inf  = (eb_raw == C_EXP_ONES) && (fb_raw == '0);
        a_nan  = (ea_raw == C_EXP_ONES) && (fa_raw != '0);
        b_nan  = (eb_raw == C_EXP_ONES) && (fb_raw != '0);
        swap_d = ({eb_raw, fb_raw} > {ea_raw, fa_raw});
        ex_d   = swap_d ? eb_raw : ea_raw;
        ey_d   = swap_d ? ea_raw : eb_raw;
        fx_d   = swap_d ? fb_raw : fa_raw;
        fy_d   = swap_d ? fa_raw : fb_raw;
        d_d    = ex_d - ey_d;
        d_ext  = CW'(d_d);
        cnt_init_d = (d_ext > C_ALIGN_MAX) ? C_ALIGN_MAX : d_ext;
    end

    // Rounding of the normalised working mantissa
    logic             g_bit, r_bit, s_bit, rnd_inc, inexact_d, ovf_d;
    logic [MAN_W:0]   man_sum_d;
    logic [EXP_W:0]   e_rnd_d;

    always_comb begin
        g_bit = ma_q[2];
        r_bit = ma_q[1];
        s_bit = ma_q[0];
`ifdef FPA_RNE_EN
        rnd_inc = g_bit & (r_bit | s_bit | ma_q[3]);
`else
        rnd_inc = 1'b0;
`endif
        man_sum_d = {1'b0, ma_q[MAN_W+2:3]} + {{MAN_W{1'b0}}, rnd_inc};
        e_rnd_d   = ea_q + {{EXP_W{1'b0}}, man_sum_d[MAN_W]};
        ovf_d     = (e_rnd_d >= {1'b0, C_EXP_ONES});
        inexact_d = g_bit | r_bit | s_bit;
    end

    // Control FSM and iterative datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sa_q        <= 1'b0;
            eff_sub_q   <= 1'b0;
            big_q       <= 1'b0;
            ea_q        <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            z_q         <= 1'b0;
            zsign_q     <= 1'b0;
            zinex_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= {bus.b[W-1] ^ bus.sub, bus.b[W-2:0]};
                        z_q        <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                    flags_q     <= 4'b0000;
                    if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]))) begin
                        result_q <= {1'b0, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                        flags_q  <= 4'b1000;
                    end else if (a_inf) begin
                        result_q <= a_q;
                    end else if (b_inf) begin
                        result_q <= b_q;
                    end else if (a_zero && b_zero) begin
                        result_q <= '0;
                        flags_q  <= 4'b0010;
                    end else if (a_zero) begin
                        result_q <= b_q;
                    end else if (b_zero) begin
                        result_q <= a_q;
                    end else begin
                        out_valid_q <= 1'b0;
                        sa_q      <= swap_d ? b_q[W-1] : a_q[W-1];
                        eff_sub_q <= a_q[W-1] ^ b_q[W-1];
                        ea_q      <= {1'b0, ex_d};
                        ma_q      <= {2'b01, fx_d, 3'b000};
                        mb_q      <= {2'b01, fy_d, 3'b000};
                        cnt_q     <= cnt_init_d;
                        big_q     <= (d_ext > C_ALIGN_MAX);
                        state_q   <= (d_d != '0) ? S_ALIGN : S_ADD;
                    end
                end
                S_ALIGN: begin
                    // A shift distance beyond the register width leaves only sticky
                    if (big_q && (cnt_q == C_ONE))
                        mb_q <= {{(MW-1){1'b0}}, |mb_q};
                    else
                        mb_q <= {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
                    cnt_q <= cnt_q - C_ONE;
                    if (cnt_q == C_ONE)
                        state_q <= S_ADD;
                end
                S_ADD: begin
                    // A holds the larger magnitude, so the difference is never negative
                    ma_q    <= eff_sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    if (ma_q == '0) begin
                        z_q     <= 1'b1;
                        zsign_q <= 1'b0;
                        zinex_q <= 1'b0;
                        state_q <= S_ROUND;
                    end else if (ma_q[MW-1]) begin
                        ma_q    <= {1'b0, ma_q[MW-1:2], ma_q[1] | ma_q[0]};
                        ea_q    <= ea_q + 1'b1;
                        state_q <= S_ROUND;
                    end else if (ma_q[MW-2]) begin
                        state_q <= S_ROUND;
                    end else begin
                        // Each cycle is one left shift; leave once the shifted value is normal
                        ma_q <= {ma_q[MW-2:0], 1'b0};
                        ea_q <= ea_q - 1'b1;
                        if (ea_q == {{EXP_W{1'b0}}, 1'b1}) begin
                            z_q     <= 1'b1;
                            zsign_q <= sa_q;
                            zinex_q <= 1'b1;
                            state_q <= S_ROUND;
                        end else if (ma_q[MW-3]) begin
                            state_q <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    if (z_q) begin
                        result_q <= {zsign_q, {(W-1){1'b0}}};
                        flags_q  <= {2'b00, 1'b1, zinex_q};
                    end else if (ovf_d) begin
                        result_q <= {sa_q, C_EXP_ONES, {MAN_W{1'b0}}};
                        flags_q  <= 4'b0101;
                    end else begin
                        result_q <= {sa_q, e_rnd_d[EXP_W-1:0], man_sum_d[MAN_W-1:0]};
                        flags_q  <= {3'b000, inexact_d};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule
`default_nettype wire

// File: tb/tb_fpa_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpa_seq
//  Description : Directed, table-driven bench for fpa_seq (half precision).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpa_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fpa_seq_if #(.EXP_W(5), .MAN_W(10)) bus ();

    fpa_seq #(.EXP_W(5), .MAN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;   // 0: latency not compared
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one operand pair and wait (bounded) for out_valid; leaves the DUT in DONE.
    task automatic run_txn(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, output logic [15:0] res, output logic [3:0] flg,
                           output int lat);
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 16'hxxxx; bus.b = 16'hxxxx; bus.sub = 1'bx;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) check({name, " timeout"}, 32'(lat), 32'd0);
        res = bus.result;
        flg = bus.flags;
    endtask

    task automatic release_result(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, " out_valid after accept"}, 32'(bus.out_valid), 32'd0);
        check({name, " in_ready after accept"},  32'(bus.in_ready),  32'd1);
    endtask

    vec_t tbl[12];

    initial begin
        logic [15:0] res, hold;
        logic [3:0]  flg;
        int          lat;

        tbl[0]  = '{"1+1",        16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 4};
        tbl[1]  = '{"1.5+0.25",   16'h3E00, 16'h3400, 1'b0, 16'h3F00, 4'b0000, 6};
        tbl[2]  = '{"0.25+1.5",   16'h3400, 16'h3E00, 1'b0, 16'h3F00, 4'b0000, 6};
        tbl[3]  = '{"1-1",        16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0010, 4};
        tbl[4]  = '{"max+max",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, 4};
        tbl[5]  = '{"inf-inf",    16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000, 1};
        tbl[6]  = '{"0+1",        16'h0000, 16'h3C00, 1'b0, 16'h3C00, 4'b0000, 1};
        tbl[7]  = '{"nan+1",      16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000, 1};
        tbl[8]  = '{"inf+1",      16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000, 1};
        tbl[9]  = '{"-0+0",       16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b0010, 1};
        tbl[10] = '{"1-0.5",      16'h3C00, 16'h3800, 1'b1, 16'h3800, 4'b0000, 0};
`ifdef FPA_RNE_EN
        tbl[11] = '{"round",      16'h3C00, 16'h1200, 1'b0, 16'h3C01, 4'b0001, 15};
`else
        tbl[11] = '{"round",      16'h3C00, 16'h1200, 1'b0, 16'h3C00, 4'b0001, 15};
`endif

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result",    32'(bus.result),    32'd0);
        check("reset flags",     32'(bus.flags),     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].sub, res, flg, lat);
            check({tbl[i].name, " result"}, 32'(res), 32'(tbl[i].res));
            check({tbl[i].name, " flags"},  32'(flg), 32'(tbl[i].flg));
            if (tbl[i].lat != 0)
                check({tbl[i].name, " latency"}, 32'(lat), 32'(tbl[i].lat));
            release_result(tbl[i].name);
        end

        // Backpressure: result held while the consumer stalls
        run_txn("bp", 16'h3C00, 16'h3C00, 1'b0, hold, flg, lat);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp result stable", 32'(bus.result),    32'h4000);
            check("bp in_ready low",  32'(bus.in_ready),  32'd0);
            check("bp out_valid",     32'(bus.out_valid), 32'd1);
        end
        release_result("bp");

        // Reset while aligning a long shift
        check("rst pre in_ready", 32'(bus.in_ready), 32'd1);
        bus.a = 16'h3C00; bus.b = 16'h1200; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        check("rst result",    32'(bus.result),    32'd0);
        run_txn("post-rst 1+1", 16'h3C00, 16'h3C00, 1'b0, res, flg, lat);
        check("post-rst result",  32'(res), 32'h4000);
        check("post-rst flags",   32'(flg), 32'd0);
        check("post-rst latency", 32'(lat), 32'd4);
        release_result("post-rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
